systolic_mxu_param: RTL

//  Parametrised weight-stationary NxN systolic matrix-vector unit; next generation of the 4x4 accelerator.

---
 rtl/systolic_mxu_param.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_mxu_param.sv
// rtl/systolic_mxu_param.sv - parametrised weight-stationary NxN systolic matrix-vector unit
module systolic_mxu_param #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [N*DATA_W-1:0]   w_row,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [N*DATA_W-1:0]   a_vec,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [N*ACC_W-1:0]    r_vec,
    output logic                  weights_loaded,
    output logic                  busy
);

    localparam int CW = $clog2(N);
    localparam int VD = 2 * N;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              w_wr;
    logic [CW-1:0]     w_idx;
    logic              adv;
    logic              a_acc;
    logic [VD-1:0]     v_pipe;

    logic [DATA_W-1:0] w_mem    [N][N];
    logic [DATA_W-1:0] skew_out [N];
    logic [DATA_W-1:0] act_o    [N][N];
    logic [ACC_W-1:0]  psum_o   [N][N];
    logic [ACC_W-1:0]  dsk_out  [N];
    logic [N*ACC_W-1:0] res_pack;

    // Global stall: everything downstream of the input holds while the result is unconsumed.
    assign adv            = !r_valid || r_ready;
    assign busy           = (|v_pipe) || r_valid;
    assign a_acc          = a_valid && a_ready;
    assign weights_loaded = (state == S_RUN);

    // State and load-beat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, handshake readiness and weight-row write select; loads go bottom row first.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        w_wr      = 1'b0;
        w_idx     = CW'(N - 1);
        case (state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_wr      = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                w_idx   = CW'(N - 1) - cnt;
                if (w_valid) begin
                    w_wr = 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_RUN;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_RUN: begin
                // A reload may only start with nothing in flight, and it beats a pending vector.
                w_ready = !busy;
                a_ready = adv && !(w_valid && !busy);
                if (w_valid && !busy) begin
                    w_wr      = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Stationary weight storage, one row written per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w_mem[i][j] <= '0;
        end else if (w_wr) begin
            for (int j = 0; j < N; j++)
                w_mem[w_idx][j] <= w_row[j*DATA_W +: DATA_W];
        end
    end

    // Vector-valid tracker; its tail lines up with the deskewed column outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
        end else if (adv) begin
            v_pipe <= {v_pipe[VD-2:0], a_acc};
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_skew
        logic [DATA_W-1:0] sr [0:gi];

        // Input register plus gi delay stages so lane gi meets its partial sum in row gi.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= gi; k++) sr[k] <= '0;
            end else if (adv) begin
                sr[0] <= a_acc ? a_vec[gi*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= gi; k++) sr[k] <= sr[k-1];
            end
        end

        assign skew_out[gi] = sr[gi];
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [DATA_W-1:0]   a_in;
            logic [ACC_W-1:0]    p_in;
            logic [2*DATA_W-1:0] pm;
            logic [ACC_W-1:0]    prod;
            logic [DATA_W-1:0]   a_q;
            logic [ACC_W-1:0]    p_q;

            if (gj == 0) begin : g_ain_edge
                assign a_in = skew_out[gi];
            end else begin : g_ain_mid
                assign a_in = act_o[gi][gj-1];
            end

            if (gi == 0) begin : g_pin_top
                assign p_in = '0;
            end else begin : g_pin_mid
                assign p_in = psum_o[gi-1][gj];
            end

            if (SIGNED != 0) begin : g_smul
                assign pm   = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in})
                            * $signed({{DATA_W{w_mem[gi][gj][DATA_W-1]}}, w_mem[gi][gj]});
                assign prod = ACC_W'($signed(pm));
            end else begin : g_umul
                assign pm   = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w_mem[gi][gj]};
                assign prod = ACC_W'(pm);
            end

            // Activation moves right, partial sum moves down; the sum wraps at ACC_W.
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    p_q <= '0;
                end else if (adv) begin
                    a_q <= a_in;
                    p_q <= p_in + prod;
                end
            end

            assign act_o[gi][gj]  = a_q;
            assign psum_o[gi][gj] = p_q;
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_dsk
        localparam int D = N - 1 - gj;

        if (D == 0) begin : g_pass
            assign dsk_out[gj] = psum_o[N-1][gj];
        end else begin : g_delay
            logic [ACC_W-1:0] dq [0:D-1];

            // Later columns finish later, so earlier columns wait D cycles to realign.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dq[k] <= '0;
                end else if (adv) begin
                    dq[0] <= psum_o[N-1][gj];
                    for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
                end
            end

            assign dsk_out[gj] = dq[D-1];
        end
    end

    // Pack the realigned column sums into the result lanes.
    always_comb begin
        res_pack = '0;
        for (int j = 0; j < N; j++)
            res_pack[j*ACC_W +: ACC_W] = dsk_out[j];
    end

    // Output register: loads only on a valid result, holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_vec   <= '0;
        end else if (adv) begin
            r_valid <= v_pipe[VD-1];
            if (v_pipe[VD-1]) r_vec <= res_pack;
        end
    end

endmodule
